// File: rtl/accumulator_requantizer.sv
// Requantizes signed systolic-array accumulators to int8: beta scale, rounding shift, optional ReLU, saturation.
// Two-register valid/ready pipeline with a per-tile output index and a sticky saturation flag.
module accumulator_requantizer #(
    parameter int ACC_W   = 17,
    parameter int SCALE_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [ACC_W-1:0]   acc_data,
    input  logic               acc_last,
    input  logic               cfg_load,
    output logic               cfg_ack,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [4:0]         cfg_shift,
    input  logic               cfg_relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last,
    output logic [CNT_W-1:0]   out_index,
    output logic               sat_flag
);

    localparam int P_W = ACC_W + SCALE_W + 1;
    localparam logic [4:0] MAX_SHIFT = 5'd24;
    localparam logic signed [P_W:0] I8_MAX = (P_W+1)'(127);
    localparam logic signed [P_W:0] I8_MIN = (P_W+1)'(-128);

    // Active configuration, only ever updated while the pipeline is empty
    logic [SCALE_W-1:0] scale_q;
    logic [4:0]         shift_q;
    logic               relu_q;

    logic                  s1_valid;
    logic signed [P_W-1:0] s1_p;
    logic                  s1_last;

    logic s2_adv, s1_adv, pipe_empty, acc_fire, out_fire;

    assign s2_adv     = !out_valid || out_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign pipe_empty = !s1_valid && !out_valid;
    assign acc_ready  = rst_n && s1_adv && !(cfg_load && pipe_empty);
    assign acc_fire   = acc_valid && acc_ready;
    assign cfg_ack    = rst_n && cfg_load && pipe_empty && !acc_fire;
    assign out_fire   = out_valid && out_ready;

    // Beta is unsigned, so it is zero-extended before the signed multiply
    logic signed [P_W-1:0] acc_ext, scale_ext, product;
    assign acc_ext   = P_W'($signed(acc_data));
    assign scale_ext = P_W'({1'b0, scale_q});
    assign product   = acc_ext * scale_ext;

    logic [4:0]          sh;
    logic signed [P_W:0] rnd, sum, shifted, clipped;
    logic [7:0]          q8;
    logic                q_sat;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        q8      = '0;
        q_sat   = 1'b0;
        rnd     = '0;
        sh      = (shift_q > MAX_SHIFT) ? MAX_SHIFT : shift_q;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        // One guard bit keeps the rounding add from overflowing at maximum magnitude
        sum     = {s1_p[P_W-1], s1_p} + rnd;
        shifted = sum >>> sh;
        clipped = (relu_q && shifted[P_W]) ? '0 : shifted;
        if (clipped > I8_MAX) begin
            q8    = 8'h7f;
            q_sat = 1'b1;
        end else if (clipped < I8_MIN) begin
            q8    = 8'h80;
            q_sat = 1'b1;
        end else begin
            q8 = clipped[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; datapath registers are reset too
    // because they drive module outputs that must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scale_q   <= SCALE_W'(1);
            shift_q   <= '0;
            relu_q    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_index <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (cfg_ack) begin
                scale_q <= cfg_scale;
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end

            if (s1_adv) begin
                s1_valid <= acc_fire;
                if (acc_fire) begin
                    s1_p    <= product;
                    s1_last <= acc_last;
                end
            end

            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= q8;
                    out_last <= s1_last;
                end
            end

            if (cfg_ack)
                sat_flag <= 1'b0;
            else if (s2_adv && s1_valid && q_sat)
                sat_flag <= 1'b1;

            if (out_fire)
                out_index <= out_last ? '0 : out_index + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_accumulator_requantizer.sv
// Self-checking bench for accumulator_requantizer: directed scenarios plus randomized streams
// checked against an arithmetic reference model.
module tb_accumulator_requantizer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] index;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acc_valid, acc_ready;
    logic [16:0] acc_data;
    logic        acc_last;
    logic        cfg_load, cfg_ack;
    logic [7:0]  cfg_scale;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [3:0]  out_index;
    logic        sat_flag;

    int   tests_run    = 0;
    int   tests_failed = 0;
    obs_t out_log[$];
    int   acc_count;

    // Reference model state
    int         cur_scale, cur_shift;
    bit         cur_relu;
    logic [3:0] m_index;
    bit         m_sat;

    always #5 clk = ~clk;

    accumulator_requantizer #(.ACC_W(17), .SCALE_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_last(acc_last),
        .cfg_load(cfg_load), .cfg_ack(cfg_ack), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_index(out_index), .sat_flag(sat_flag)
    );

    // Observe transfers half a cycle before the edge that completes them
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_valid && acc_ready) acc_count++;
            if (out_valid && out_ready) out_log.push_back({out_data, out_last, out_index});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exact arithmetic: scale, add half, floor-divide by 2^sh, ReLU, clamp to int8
    function automatic obs_t model(input int acc, input bit last);
        longint p, d, num, r;
        int     sh;
        obs_t   o;
        p   = longint'(acc) * cur_scale;
        sh  = (cur_shift > 24) ? 24 : cur_shift;
        d   = longint'(1) << sh;
        num = p + ((sh > 0) ? d / 2 : 0);
        r   = (num >= 0) ? num / d : -((-num + d - 1) / d);
        if (cur_relu && r < 0) r = 0;
        if (r > 127) begin
            r = 127; m_sat = 1'b1;
        end else if (r < -128) begin
            r = -128; m_sat = 1'b1;
        end
        o.data  = 8'(r);
        o.last  = last;
        o.index = m_index;
        m_index = last ? 4'd0 : m_index + 4'd1;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; acc_valid = 1'b0; acc_data = '0; acc_last = 1'b0;
        cfg_load = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_relu = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        out_log.delete();
        acc_count = 0; m_index = '0; m_sat = 1'b0;
        cur_scale = 1; cur_shift = 0; cur_relu = 1'b0;
    endtask

    task automatic load_cfg(input int scale, input int shift, input bit relu);
        bit got = 1'b0;
        cfg_scale = 8'(scale); cfg_shift = 5'(shift); cfg_relu = relu; cfg_load = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = cfg_ack;
            tick();
        end
        cfg_load = 1'b0;
        tests_run++;
        if (got !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_ack_timeout: got ack=%0b want 1", got);
        end else begin
            cur_scale = scale; cur_shift = shift; cur_relu = relu; m_sat = 1'b0;
        end
    endtask

    task automatic drive_stream(input int vals[$], input bit lasts[$]);
        int n_acc = 0;
        bit got;
        foreach (vals[i]) begin
            acc_valid = 1'b1; acc_data = 17'(vals[i]); acc_last = lasts[i]; got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                got = acc_ready;
                tick();
            end
            if (!got) break;
            n_acc++;
        end
        acc_valid = 1'b0; acc_last = 1'b0;
        tests_run++;
        if (n_acc !== vals.size()) begin
            tests_failed++;
            $display("FAIL acc_accept_timeout: accepted %0d want %0d", n_acc, vals.size());
        end
    endtask

    task automatic wait_outputs(input int n);
        for (int c = 0; c < 500 && out_log.size() < n; c++) tick();
        repeat (4) tick();
        tests_run++;
        if (out_log.size() !== n) begin
            tests_failed++;
            $display("FAIL output_count: got %0d results want %0d", out_log.size(), n);
        end
    endtask

    task automatic test_reset();
        int   v[$];
        bit   l[$];
        obs_t want[$];
        obs_t got;
        do_reset();
        rst_n = 1'b0; cfg_load = 1'b1; acc_valid = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if ({acc_ready, cfg_ack, out_valid, out_data, out_last, out_index, sat_flag} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%0b ack=%0b vld=%0b data=%0d last=%0b idx=%0d sat=%0b want all 0",
                     acc_ready, cfg_ack, out_valid, out_data, out_last, out_index, sat_flag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; cfg_load = 1'b0; acc_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (acc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %0b want 1", acc_ready);
        end
        // Default config is scale 1, shift 0: values pass through
        v = '{5, 6}; l = '{1'b1, 1'b0};
        want.push_back({8'd5, 1'b1, 4'd0});
        want.push_back({8'd6, 1'b0, 4'd0});
        tick();
        drive_stream(v, l);
        wait_outputs(2);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            got = (i < out_log.size()) ? out_log[i] : '0;
            if (got !== want[i]) begin
                tests_failed++;
                $display("FAIL reset_default_cfg[%0d]: got data=%0d last=%0b idx=%0d want data=%0d last=%0b idx=%0d",
                         i, $signed(got.data), got.last, got.index, $signed(want[i].data), want[i].last, want[i].index);
            end
        end
    endtask

    task automatic test_basic();
        obs_t want[$];
        obs_t got;
        do_reset();
        load_cfg(1, 3, 0);
        want.push_back({8'd125, 1'b0, 4'd0});
        want.push_back({8'd125, 1'b0, 4'd1});
        want.push_back({8'd126, 1'b0, 4'd2});
        // Presented after edge N, accepted at N+1, result visible after N+2
        acc_valid = 1'b1; acc_data = 17'd1000; acc_last = 1'b0;
        @(negedge clk);
        tests_run++;
        if (acc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready: got %0b want 1", acc_ready);
        end
        tick();
        acc_data = 17'd1003;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_latency_early: out_valid got %0b want 0", out_valid);
        end
        tick();
        acc_data = 17'd1004;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'd125) begin
            tests_failed++;
            $display("FAIL basic_latency: out_valid=%0b data=%0d want 1 / 125", out_valid, $signed(out_data));
        end
        tick();
        acc_valid = 1'b0;
        wait_outputs(3);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            got = (i < out_log.size()) ? out_log[i] : '0;
            if (got !== want[i]) begin
                tests_failed++;
                $display("FAIL basic[%0d]: got data=%0d last=%0b idx=%0d want data=%0d last=%0b idx=%0d",
                         i, $signed(got.data), got.last, got.index, $signed(want[i].data), want[i].last, want[i].index);
            end
        end
    endtask

    task automatic test_saturation();
        int          v[$];
        bit          l[$];
        logic [7:0]  want_d[6] = '{8'h80, 8'hff, 8'hff, 8'h01, 8'hff, 8'h00};
        bit          want_s[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        load_cfg(2, 2, 0);
        v = '{-300}; l = '{1'b0};
        drive_stream(v, l); wait_outputs(1);
        v = '{-3};
        drive_stream(v, l); wait_outputs(2);
        // A new config clears the sticky flag
        load_cfg(1, 1, 0);
        v = '{-3};
        drive_stream(v, l); wait_outputs(3);
        // Shift 31 behaves as 24
        load_cfg(255, 31, 0);
        v = '{65535};
        drive_stream(v, l); wait_outputs(4);
        v = '{-65536};
        drive_stream(v, l); wait_outputs(5);
        v = '{0};
        drive_stream(v, l); wait_outputs(6);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (i >= out_log.size() || out_log[i].data !== want_d[i]) begin
                tests_failed++;
                $display("FAIL saturation[%0d]: got data=%0d want %0d", i,
                         (i < out_log.size()) ? $signed(out_log[i].data) : 8'sd0, $signed(want_d[i]));
            end
        end
        tests_run++;
        if (sat_flag !== want_s[5]) begin
            tests_failed++;
            $display("FAIL saturation_flag_final: got %0b want %0b", sat_flag, want_s[5]);
        end
    endtask

    task automatic test_sat_sticky();
        int v[$];
        bit l[$];
        do_reset();
        load_cfg(2, 2, 0);
        v = '{-300}; l = '{1'b0};
        drive_stream(v, l); wait_outputs(1);
        tests_run++;
        if (sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_set: got %0b want 1", sat_flag);
        end
        v = '{-3};
        drive_stream(v, l); wait_outputs(2);
        tests_run++;
        if (sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_sticky: got %0b want 1", sat_flag);
        end
        load_cfg(1, 1, 0);
        @(negedge clk);
        tests_run++;
        if (sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_clear_on_ack: got %0b want 0", sat_flag);
        end
    endtask

    task automatic test_relu();
        int         v[$];
        bit         l[$];
        logic [7:0] want_d[3] = '{8'd0, 8'd7, 8'd127};
        do_reset();
        load_cfg(1, 0, 1);
        v = '{-5}; l = '{1'b0};
        drive_stream(v, l); wait_outputs(1);
        tests_run++;
        if (sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL relu_no_sat: got %0b want 0", sat_flag);
        end
        v = '{7, 200}; l = '{1'b0, 1'b0};
        drive_stream(v, l); wait_outputs(3);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= out_log.size() || out_log[i].data !== want_d[i]) begin
                tests_failed++;
                $display("FAIL relu[%0d]: got data=%0d want %0d", i,
                         (i < out_log.size()) ? $signed(out_log[i].data) : 8'sd0, $signed(want_d[i]));
            end
        end
        tests_run++;
        if (sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL relu_sat: got %0b want 1", sat_flag);
        end
    endtask

    task automatic test_backpressure();
        int         v[$];
        bit         l[$];
        obs_t       want[$];
        obs_t       got;
        bit         seen_low = 1'b0;
        bit         have_prev = 1'b0;
        logic [7:0] prev = '0;
        do_reset();
        load_cfg(3, 1, 0);
        for (int i = 0; i < 8; i++) begin
            v.push_back(int'($urandom_range(0, 160)) - 80);
            l.push_back(1'b0);
            want.push_back(model(v[i], 1'b0));
        end
        fork
            drive_stream(v, l);
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(negedge clk); #1;
                    if (!acc_ready && acc_valid && !seen_low) begin
                        seen_low = 1'b1;
                        tests_run++;
                        if (acc_count - out_log.size() !== 2) begin
                            tests_failed++;
                            $display("FAIL bp_buffered: got %0d in flight want 2", acc_count - out_log.size());
                        end
                    end
                    if (out_valid && !out_ready) begin
                        if (have_prev) begin
                            tests_run++;
                            if (out_data !== prev) begin
                                tests_failed++;
                                $display("FAIL bp_hold: got data=%0d want %0d", $signed(out_data), $signed(prev));
                            end
                        end
                        prev = out_data; have_prev = 1'b1;
                    end else begin
                        have_prev = 1'b0;
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        tests_run++;
        if (!seen_low) begin
            tests_failed++;
            $display("FAIL bp_ready_drop: acc_ready low seen=%0b want 1", seen_low);
        end
        wait_outputs(8);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            got = (i < out_log.size()) ? out_log[i] : '0;
            if (got !== want[i]) begin
                tests_failed++;
                $display("FAIL bp[%0d]: got data=%0d last=%0b idx=%0d want data=%0d last=%0b idx=%0d",
                         i, $signed(got.data), got.last, got.index, $signed(want[i].data), want[i].last, want[i].index);
            end
        end
    endtask

    task automatic test_tile_cfg();
        int         v[$];
        bit         l[$] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] want_idx[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        obs_t       want[$];
        obs_t       got;
        bit         ack = 1'b0;
        int         outs_at_ack = -1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            v.push_back(int'($urandom_range(0, 200)) - 100);
            want.push_back(model(v[i], l[i]));
            want[i].index = want_idx[i];
        end
        fork
            drive_stream(v, l);
            begin
                tick(); tick();
                cfg_scale = 8'd3; cfg_shift = 5'd0; cfg_relu = 1'b0; cfg_load = 1'b1;
                for (int c = 0; c < 100 && !ack; c++) begin
                    @(negedge clk); #1;
                    ack = cfg_ack;
                    if (ack) outs_at_ack = out_log.size();
                    @(posedge clk); #1;
                end
                cfg_load = 1'b0;
                if (ack) begin
                    cur_scale = 3; cur_shift = 0; cur_relu = 1'b0; m_sat = 1'b0;
                end
            end
        join
        tests_run++;
        if (outs_at_ack !== 6) begin
            tests_failed++;
            $display("FAIL tile_cfg_ack_after_drain: results before ack got %0d want 6", outs_at_ack);
        end
        wait_outputs(6);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            got = (i < out_log.size()) ? out_log[i] : '0;
            if (got !== want[i]) begin
                tests_failed++;
                $display("FAIL tile[%0d]: got data=%0d last=%0b idx=%0d want data=%0d last=%0b idx=%0d",
                         i, $signed(got.data), got.last, got.index, $signed(want[i].data), want[i].last, want[i].index);
            end
        end
        v = '{10}; l = '{1'b0};
        drive_stream(v, l); wait_outputs(7);
        tests_run++;
        got = (out_log.size() > 6) ? out_log[6] : '0;
        if (got !== {8'd30, 1'b0, 4'd2}) begin
            tests_failed++;
            $display("FAIL tile_new_cfg: got data=%0d idx=%0d want data=30 idx=2", $signed(got.data), got.index);
        end
    endtask

    task automatic test_mid_reset();
        int v[$];
        bit l[$];
        do_reset();
        load_cfg(5, 3, 1);
        out_ready = 1'b0;
        v = '{300, 5}; l = '{1'b0, 1'b0};
        drive_stream(v, l);
        @(negedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || acc_ready !== 1'b0 || sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_full: got vld=%0b rdy=%0b sat=%0b want 1 0 1", out_valid, acc_ready, sat_flag);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || sat_flag !== 1'b0 || out_index !== 4'd0 || acc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_after: got vld=%0b sat=%0b idx=%0d rdy=%0b want 0 0 0 1",
                     out_valid, sat_flag, out_index, acc_ready);
        end
        out_ready = 1'b1;
        tick();
        v = '{64}; l = '{1'b0};
        drive_stream(v, l);
        wait_outputs(1);
        tests_run++;
        if (out_log.size() < 1 || out_log[0] !== {8'd64, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL midrst_next: got data=%0d idx=%0d want data=64 idx=0",
                     (out_log.size() > 0) ? $signed(out_log[0].data) : 8'sd0,
                     (out_log.size() > 0) ? out_log[0].index : 4'd0);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            int   v[$];
            bit   l[$];
            obs_t want[$];
            obs_t got;
            bit   done = 1'b0;
            do_reset();
            load_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 40; i++) begin
                v.push_back(int'($urandom_range(0, 131071)) - 65536);
                l.push_back($urandom_range(0, 7) == 0);
                want.push_back(model(v[i], l[i]));
            end
            fork
                begin
                    drive_stream(v, l);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                    out_ready = 1'b1;
                end
            join
            wait_outputs(40);
            for (int i = 0; i < 40; i++) begin
                tests_run++;
                got = (i < out_log.size()) ? out_log[i] : '0;
                if (got !== want[i]) begin
                    tests_failed++;
                    $display("FAIL random%0d[%0d]: acc=%0d got data=%0d last=%0b idx=%0d want data=%0d last=%0b idx=%0d",
                             round, i, v[i], $signed(got.data), got.last, got.index,
                             $signed(want[i].data), want[i].last, want[i].index);
                end
            end
            tests_run++;
            if (sat_flag !== m_sat) begin
                tests_failed++;
                $display("FAIL random%0d_sat: got %0b want %0b", round, sat_flag, m_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_sticky();
        test_saturation();
        test_relu();
        test_backpressure();
        test_tile_cfg();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
